slot_config_scanner: RTL and testbench

- Parametrised per-slot direction/channel detection for the converter bus; replaces the hard-wired direction and channel constants in the top level.
- Serially scans the DIR/CHAN line once per frame and debounces the result across frames.
- Publishes registered per-slot direction/channel vectors and slot-data output enables to the converter modules and slot tristate logic.
- Sits between the isolated 40-pin bus pins and the dac/adc slot instances.

---
 rtl/slot_config_scanner.sv | 252 +++++++++++++++++++++++++
 tb/tb_slot_config_scanner.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_config_scanner.sv
// Serial DIR/CHAN scanner for the converter bus: shifts one frame per scan,
// debounces identical frames and publishes registered per-slot configuration.
module slot_config_scanner #(
   parameter int N_SLOTS       = 4,
   parameter int CLK_DIV       = 8,
   parameter int STABLE_FRAMES = 3,
   parameter int FRAME_GAP     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               scan_enable,
   input  logic               custom_dirchan,
   output logic               custom_srclk,
   output logic               scan_load,
   output logic [N_SLOTS-1:0] directions,
   output logic [N_SLOTS-1:0] channels,
   output logic [N_SLOTS-1:0] slot_out_en,
   output logic               config_valid,
   output logic               config_changed,
   output logic               scan_busy
);

   localparam int FRAME_W  = 2 * N_SLOTS;
   localparam int LOAD_LEN = 2 * CLK_DIV;
   localparam int MAX_LEN  = (LOAD_LEN > FRAME_GAP) ? LOAD_LEN : FRAME_GAP;
   localparam int CNT_W    = $clog2(MAX_LEN + 1);
   localparam int BIT_W    = $clog2(FRAME_W);
   localparam int SC_W     = $clog2(STABLE_FRAMES + 1);

   if (N_SLOTS < 1 || N_SLOTS > 16) begin : g_badSlots
      $error("N_SLOTS must be in 1..16");
   end
   if (CLK_DIV < 1) begin : g_badDiv
      $error("CLK_DIV must be at least 1");
   end
   if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_badStable
      $error("STABLE_FRAMES must be in 1..15");
   end
   if (FRAME_GAP < 1) begin : g_badGap
      $error("FRAME_GAP must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_COMPARE,
      S_GAP
   } state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [BIT_W-1:0]   r_bit;
   logic               r_half;
   logic [FRAME_W-1:0] r_frame;
   logic [FRAME_W-1:0] r_lastFrame;
   logic [SC_W-1:0]    r_stableCnt;
   logic               r_srclk;
   logic               r_load;
   logic               r_busy;
   logic [N_SLOTS-1:0] r_dirs;
   logic [N_SLOTS-1:0] r_chans;
   logic [N_SLOTS-1:0] r_outEn;
   logic               r_valid;
   logic               r_changed;

   state_t             w_nextState;
   logic [CNT_W-1:0]   w_nextCnt;
   logic [BIT_W-1:0]   w_nextBit;
   logic               w_nextHalf;
   logic               w_sample;
   logic               w_abort;
   logic               w_match;
   logic [SC_W:0]      w_cntInc;
   logic [SC_W-1:0]    w_newCnt;
   logic               w_commit;
   logic               w_differs;
   logic [N_SLOTS-1:0] w_newDirs;
   logic [N_SLOTS-1:0] w_newChans;

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_nextBit   = r_bit;
      w_nextHalf  = r_half;
      w_sample    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (scan_enable) begin
               w_nextState = S_LOAD;
               w_nextCnt   = '0;
            end
         end
         S_LOAD: begin
            if (!scan_enable) begin
               w_nextState = S_IDLE;
               w_nextCnt   = '0;
            end else if (r_cnt == CNT_W'(LOAD_LEN - 1)) begin
               w_nextState = S_SHIFT;
               w_nextCnt   = '0;
               w_nextBit   = '0;
               w_nextHalf  = 1'b0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         // Each bit is a low half followed by a high half; the bit is taken
         // on the clk that ends the high half, i.e. where srclk falls.
         S_SHIFT: begin
            if (!scan_enable) begin
               w_nextState = S_IDLE;
               w_nextCnt   = '0;
               w_nextHalf  = 1'b0;
            end else if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
               w_nextCnt = '0;
               if (!r_half) begin
                  w_nextHalf = 1'b1;
               end else begin
                  w_sample   = 1'b1;
                  w_nextHalf = 1'b0;
                  if (r_bit == BIT_W'(FRAME_W - 1)) begin
                     w_nextState = S_COMPARE;
                  end else begin
                     w_nextBit = r_bit + 1'b1;
                  end
               end
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         S_COMPARE: begin
            w_nextState = S_GAP;
            w_nextCnt   = '0;
         end
         S_GAP: begin
            if (r_cnt == CNT_W'(FRAME_GAP - 1)) begin
               w_nextState = scan_enable ? S_LOAD : S_IDLE;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_nextState = S_IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // Debounce: a commit happens only on the frame that brings the count up
   // to STABLE_FRAMES, so a saturated count does not re-commit every frame.
   always_comb begin
      w_abort    = ((r_state == S_LOAD) || (r_state == S_SHIFT)) && !scan_enable;
      w_match    = (r_frame == r_lastFrame);
      w_cntInc   = {1'b0, r_stableCnt} + 1'b1;
      w_newCnt   = SC_W'(1);
      if (w_match) begin
         if (w_cntInc > (SC_W + 1)'(STABLE_FRAMES)) begin
            w_newCnt = SC_W'(STABLE_FRAMES);
         end else begin
            w_newCnt = w_cntInc[SC_W-1:0];
         end
      end
      w_commit = (r_state == S_COMPARE) && (w_newCnt == SC_W'(STABLE_FRAMES)) &&
                 ((r_stableCnt != SC_W'(STABLE_FRAMES)) || !w_match);
      w_newDirs  = '0;
      w_newChans = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         w_newDirs[i]  = r_frame[2*i];
         w_newChans[i] = r_frame[2*i+1];
      end
      w_differs = (w_newDirs != r_dirs) || (w_newChans != r_chans) || !r_valid;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_half  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_bit   <= w_nextBit;
         r_half  <= w_nextHalf;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_srclk <= 1'b0;
         r_load  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_srclk <= (w_nextState == S_SHIFT) && w_nextHalf;
         r_load  <= (w_nextState == S_LOAD);
         r_busy  <= (w_nextState != S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame <= '0;
      end else if (w_abort) begin
         r_frame <= '0;
      end else if (w_sample) begin
         r_frame[r_bit] <= custom_dirchan;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lastFrame <= '0;
         r_stableCnt <= '0;
      end else if (w_abort) begin
         r_stableCnt <= '0;
      end else if (r_state == S_COMPARE) begin
         r_lastFrame <= r_frame;
         r_stableCnt <= w_newCnt;
      end
   end

   // Committed configuration; output enables follow the new directions in
   // the same clk so a slot is never driven while it is marked as an ADC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dirs    <= '0;
         r_chans   <= '0;
         r_outEn   <= '0;
         r_valid   <= 1'b0;
         r_changed <= 1'b0;
      end else begin
         r_changed <= w_commit && w_differs;
         if (w_commit) begin
            r_dirs  <= w_newDirs;
            r_chans <= w_newChans;
            r_outEn <= ~w_newDirs;
            r_valid <= 1'b1;
         end
      end
   end

   assign custom_srclk   = r_srclk;
   assign scan_load      = r_load;
   assign scan_busy      = r_busy;
   assign directions     = r_dirs;
   assign channels       = r_chans;
   assign slot_out_en    = r_outEn;
   assign config_valid   = r_valid;
   assign config_changed = r_changed;

endmodule

// File: tb/tb_slot_config_scanner.sv
// Directed bench for slot_config_scanner: a 4-slot debounced instance driven
// by a frame table plus a 6-slot single-frame-commit instance.
module tb_slot_config_scanner;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        enA, enB;
   logic        dirchanA, dirchanB;
   logic [7:0]  patA;
   logic [11:0] patB;

   logic        srclkA, loadA, validA, chgA, busyA;
   logic [3:0]  dirA, chA, oeA;
   logic        srclkB, loadB, validB, chgB, busyB;
   logic [5:0]  dirB, chB, oeB;

   slot_config_scanner #(
      .N_SLOTS(4), .CLK_DIV(2), .STABLE_FRAMES(3), .FRAME_GAP(16)
   ) dutA (
      .clk(clk), .reset(reset), .scan_enable(enA), .custom_dirchan(dirchanA),
      .custom_srclk(srclkA), .scan_load(loadA), .directions(dirA), .channels(chA),
      .slot_out_en(oeA), .config_valid(validA), .config_changed(chgA), .scan_busy(busyA)
   );

   slot_config_scanner #(
      .N_SLOTS(6), .CLK_DIV(2), .STABLE_FRAMES(1), .FRAME_GAP(8)
   ) dutB (
      .clk(clk), .reset(reset), .scan_enable(enB), .custom_dirchan(dirchanB),
      .custom_srclk(srclkB), .scan_load(loadB), .directions(dirB), .channels(chB),
      .slot_out_en(oeB), .config_valid(validB), .config_changed(chgB), .scan_busy(busyB)
   );

   // Bus shift-register models: restart on load, advance on each srclk fall.
   int idxA = 0;
   int idxB = 0;
   always @(posedge loadA or negedge srclkA) begin
      if (loadA) idxA <= 0;
      else       idxA <= idxA + 1;
   end
   always @(posedge loadB or negedge srclkB) begin
      if (loadB) idxB <= 0;
      else       idxB <= idxB + 1;
   end
   assign dirchanA = (idxA < 8)  ? patA[idxA[2:0]] : 1'b0;
   assign dirchanB = (idxB < 12) ? patB[idxB[3:0]] : 1'b0;

   int cyc = 0, loadClks = 0, pulseA = 0, pulseB = 0, srRiseA = 0, srRiseB = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (loadA) loadClks <= loadClks + 1;
      if (chgA)  pulseA   <= pulseA + 1;
      if (chgB)  pulseB   <= pulseB + 1;
   end
   always @(posedge srclkA) srRiseA <= srRiseA + 1;
   always @(posedge srclkB) srRiseB <= srRiseB + 1;

   int applied = 0;
   int miscompares = 0;

   typedef struct {
      logic [7:0] frame;
      logic [3:0] expDir;
      logic [3:0] expChan;
      logic [3:0] expEn;
      logic       expValid;
      int         expPulses;
   } vec_t;

   vec_t vecs[19];

   function automatic logic [7:0] mkA(input logic [3:0] d, input logic [3:0] c);
      logic [7:0] f;
      for (int i = 0; i < 4; i++) begin
         f[2*i]   = d[i];
         f[2*i+1] = c[i];
      end
      return f;
   endfunction

   function automatic logic [11:0] mkB(input logic [5:0] d, input logic [5:0] c);
      logic [11:0] f;
      for (int i = 0; i < 6; i++) begin
         f[2*i]   = d[i];
         f[2*i+1] = c[i];
      end
      return f;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic waitLoadRiseA(output bit ok);
      logic prev;
      prev = loadA;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (loadA && !prev) begin
            ok = 1'b1;
            return;
         end
         prev = loadA;
      end
   endtask

   task automatic waitSrRiseA(input int target, output bit ok);
      int s0;
      s0 = srRiseA;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         if (srRiseA - s0 == target) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic waitPulseB(output bit ok);
      int p0;
      p0 = pulseB;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (pulseB != p0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   // Called during a frame's LOAD; runs that frame and checks its result at
   // the start of the following frame.
   task automatic applyStimulus(input vec_t v, input int row);
      int c0, l0, s0, p0;
      bit ok;
      patA = v.frame;
      c0 = cyc; l0 = loadClks; s0 = srRiseA; p0 = pulseA;
      waitLoadRiseA(ok);
      checkOutput($sformatf("row%0d loadRise", row), 32'(ok), 1);
      checkOutput($sformatf("row%0d period", row), cyc - c0, 53);
      checkOutput($sformatf("row%0d loadClks", row), loadClks - l0, 4);
      checkOutput($sformatf("row%0d srclkPeriods", row), srRiseA - s0, 8);
      checkOutput($sformatf("row%0d pulses", row), pulseA - p0, v.expPulses);
      checkOutput($sformatf("row%0d directions", row), dirA, v.expDir);
      checkOutput($sformatf("row%0d channels", row), chA, v.expChan);
      checkOutput($sformatf("row%0d slotOutEn", row), oeA, v.expEn);
      checkOutput($sformatf("row%0d configValid", row), validA, v.expValid);
   endtask

   initial begin
      logic [7:0] P, Q, R, S;
      bit ok;
      int s0, sB0, p0;

      P = mkA(4'b1100, 4'b0000);
      Q = mkA(4'b1110, 4'b0000);
      R = mkA(4'b1110, 4'b0101);
      S = mkA(4'b0001, 4'b0101);
      vecs[0]  = '{P, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
      vecs[1]  = '{P, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0};
      vecs[2]  = '{P, 4'b1100, 4'b0000, 4'b0011, 1'b1, 1};
      vecs[3]  = '{P, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[4]  = '{Q, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[5]  = '{P, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[6]  = '{P, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[7]  = '{Q, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[8]  = '{Q, 4'b1100, 4'b0000, 4'b0011, 1'b1, 0};
      vecs[9]  = '{Q, 4'b1110, 4'b0000, 4'b0001, 1'b1, 1};
      vecs[10] = '{R, 4'b1110, 4'b0000, 4'b0001, 1'b1, 0};
      vecs[11] = '{R, 4'b1110, 4'b0000, 4'b0001, 1'b1, 0};
      vecs[12] = '{R, 4'b1110, 4'b0101, 4'b0001, 1'b1, 1};
      vecs[13] = '{R, 4'b1110, 4'b0101, 4'b0001, 1'b1, 0};
      vecs[14] = '{S, 4'b1110, 4'b0101, 4'b0001, 1'b1, 0};
      vecs[15] = '{S, 4'b1110, 4'b0101, 4'b0001, 1'b1, 0};
      vecs[16] = '{S, 4'b1110, 4'b0101, 4'b0001, 1'b1, 0};
      vecs[17] = '{S, 4'b1110, 4'b0101, 4'b0001, 1'b1, 0};
      vecs[18] = '{S, 4'b0001, 4'b0101, 4'b1110, 1'b1, 1};

      reset = 1'b0; enA = 1'b0; enB = 1'b0; patA = '0; patB = '0;
      #23 reset = 1'b1;

      // Idle after reset: nothing moves for 1000 clks.
      s0 = srRiseA; sB0 = srRiseB;
      repeat (1000) @(posedge clk);
      #1;
      checkOutput("idle srclkA", srRiseA - s0, 0);
      checkOutput("idle srclkB", srRiseB - sB0, 0);
      checkOutput("idle srclk level", srclkA, 0);
      checkOutput("idle scanLoad", loadA, 0);
      checkOutput("idle busy", busyA, 0);
      checkOutput("idle directions", dirA, 0);
      checkOutput("idle channels", chA, 0);
      checkOutput("idle slotOutEn", oeA, 0);
      checkOutput("idle configValid", validA, 0);
      checkOutput("idle configChanged", chgA, 0);
      checkOutput("idle B valid", validB, 0);

      // Debounce table.
      patA = vecs[0].frame;
      enA = 1'b1;
      waitLoadRiseA(ok);
      checkOutput("first loadRise", 32'(ok), 1);
      checkOutput("first busy", busyA, 1);
      for (int i = 0; i < 16; i++) applyStimulus(vecs[i], i);

      // Abort in the middle of the third S frame at bit 3.
      patA = S;
      waitSrRiseA(4, ok);
      checkOutput("abort reach bit3", 32'(ok), 1);
      enA = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort srclk", srclkA, 0);
      checkOutput("abort scanLoad", loadA, 0);
      checkOutput("abort busy", busyA, 0);
      checkOutput("abort directions", dirA, 4'b1110);
      checkOutput("abort channels", chA, 4'b0101);
      checkOutput("abort slotOutEn", oeA, 4'b0001);
      checkOutput("abort configValid", validA, 1);
      s0 = srRiseA;
      repeat (30) @(posedge clk);
      #1;
      checkOutput("abort srclk static", srRiseA - s0, 0);
      checkOutput("abort stays idle", busyA, 0);
      enA = 1'b1;
      waitLoadRiseA(ok);
      checkOutput("reenable loadRise", 32'(ok), 1);
      for (int i = 16; i < 19; i++) applyStimulus(vecs[i], i);

      // Asynchronous reset pulse between clk edges, mid-SHIFT.
      waitSrRiseA(2, ok);
      checkOutput("reset reach shift", 32'(ok), 1);
      #1 reset = 1'b0;
      #1;
      checkOutput("async configValid", validA, 0);
      checkOutput("async directions", dirA, 0);
      checkOutput("async channels", chA, 0);
      checkOutput("async slotOutEn", oeA, 0);
      checkOutput("async srclk", srclkA, 0);
      checkOutput("async busy", busyA, 0);
      enA = 1'b0;
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("post reset idle", busyA, 0);

      // Six slots, single-frame commit.
      patB = mkB(6'b000111, 6'b101010);
      sB0 = srRiseB;
      enB = 1'b1;
      waitPulseB(ok);
      checkOutput("B first pulse", 32'(ok), 1);
      checkOutput("B srclkPeriods", srRiseB - sB0, 12);
      checkOutput("B channels", chB, 6'b101010);
      checkOutput("B directions", dirB, 6'b000111);
      checkOutput("B slotOutEn", oeB, 6'b111000);
      checkOutput("B configValid", validB, 1);
      patB = mkB(6'b000111, 6'b010101);
      sB0 = srRiseB;
      waitPulseB(ok);
      checkOutput("B second pulse", 32'(ok), 1);
      checkOutput("B srclkPeriods2", srRiseB - sB0, 12);
      checkOutput("B channels2", chB, 6'b010101);
      p0 = pulseB;
      repeat (80) @(posedge clk);
      #1;
      checkOutput("B repeat no pulse", pulseB - p0, 0);
      checkOutput("B channels held", chB, 6'b010101);
      enB = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
